// File: rtl/branch_target_sequencer.sv
// ============================================================================
// branch_target_sequencer
// ----------------------------------------------------------------------------
// Multi-cycle next-PC controller for the MIPS datapath. The control unit
// issues a request (start/op) with the current PC and operands. The block
// steps through PC increment, branch-offset shift (sign-extended imm16 << 2),
// target addition and jump/jr target formation. It then presents a single
// next_pc with a one-cycle pc_write strobe to the PC register.
//
// Optional feature macro: PC_SEQ_ALIGN_CHECK_EN
//   defined     : jr targets with rs_val[1:0] != 0 are word-aligned by
//                 clearing the low bits, and misalign pulses with done.
//   not defined : the misalign port is absent, and jr uses rs_val verbatim.
//
// Parameters
//   RESET_PC  value driven on next_pc after reset
//   PC_INC    sequential increment added to pc in the INC step
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   start     in   1   request, accepted only when the sequencer is idle
//   op        in   2   00 seq, 01 branch, 10 jump, 11 jr
//   pc        in   32  current PC (latched on accept)
//   imm       in   16  branch offset in words (latched on accept)
//   jaddr     in   26  jump index (latched on accept)
//   rs_val    in   32  jr target (latched on accept)
//   take      in   1   branch condition (latched on accept)
//   busy      out  1   high from the cycle after accept through the done cycle
//   done      out  1   one-cycle pulse, next_pc valid
//   pc_write  out  1   PC register load enable, identical to done
//   next_pc   out  32  computed next PC, held until the next done
//   misalign  out  1   (feature build only) jr target was not word aligned
// ============================================================================
module branch_target_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    input  logic [31:0] rs_val,
    input  logic        take,
    output logic        busy,
    output logic        done,
    output logic        pc_write,
`ifdef PC_SEQ_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic [31:0] next_pc
);

    // ------------------------------------------------------------------
    // Operation and state encodings
    // ------------------------------------------------------------------
    localparam logic [1:0] OP_SEQ    = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_JUMP   = 2'b10;
    localparam logic [1:0] OP_JR     = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INC   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ADD   = 3'd3,
        ST_JMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t state_reg;

    // Operands captured at accept. Later changes on the inputs have no effect.
    logic [1:0]  op_reg;
    logic [31:0] pc_reg;
    logic [15:0] imm_reg;
    logic [25:0] jaddr_reg;
    logic [31:0] rs_val_reg;
    logic        take_reg;

    // Intermediate results of the sequenced steps
    logic [31:0] pc4_reg;
    logic [31:0] off_reg;

    // ------------------------------------------------------------------
    // Per-step arithmetic. Each step's result is computed combinationally
    // from registered operands and captured on the step's exit edge.
    // ------------------------------------------------------------------
    logic [31:0] pc4_next;
    logic [31:0] off_next;
    logic [31:0] add_next;
    logic [31:0] jmp_next;
    logic [31:0] jr_next;
    logic        jr_misalign;

    always_comb begin
        pc4_next = pc_reg + PC_INC;
        off_next = {{14{imm_reg[15]}}, imm_reg, 2'b00};
        add_next = pc4_reg + off_reg;
        jmp_next = {pc4_reg[31:28], jaddr_reg, 2'b00};
`ifdef PC_SEQ_ALIGN_CHECK_EN
        jr_next     = {rs_val_reg[31:2], 2'b00};
        jr_misalign = |rs_val_reg[1:0];
`else
        jr_next     = rs_val_reg;
        jr_misalign = 1'b0;
`endif
    end

    // ------------------------------------------------------------------
    // Sequencer. All outputs are registered. next_pc is loaded on the same
    // edge that enters DONE, so it is already valid while done is high.
    // ------------------------------------------------------------------
    logic misalign_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            op_reg       <= 2'b00;
            pc_reg       <= 32'h0;
            imm_reg      <= 16'h0;
            jaddr_reg    <= 26'h0;
            rs_val_reg   <= 32'h0;
            take_reg     <= 1'b0;
            pc4_reg      <= 32'h0;
            off_reg      <= 32'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pc_write     <= 1'b0;
            misalign_reg <= 1'b0;
            next_pc      <= RESET_PC;
        end else begin
            // Strobes default low. Only the DONE-entry transitions raise them.
            done         <= 1'b0;
            pc_write     <= 1'b0;
            misalign_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg     <= op;
                        pc_reg     <= pc;
                        imm_reg    <= imm;
                        jaddr_reg  <= jaddr;
                        rs_val_reg <= rs_val;
                        take_reg   <= take;
                        busy       <= 1'b1;
                        state_reg  <= ST_INC;
                    end
                end

                ST_INC: begin
                    pc4_reg <= pc4_next;
                    case (op_reg)
                        OP_SEQ: begin
                            next_pc   <= pc4_next;
                            done      <= 1'b1;
                            pc_write  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                        OP_BRANCH: begin
                            if (take_reg) begin
                                state_reg <= ST_SHIFT;
                            end else begin
                                next_pc   <= pc4_next;
                                done      <= 1'b1;
                                pc_write  <= 1'b1;
                                state_reg <= ST_DONE;
                            end
                        end
                        OP_JUMP: begin
                            state_reg <= ST_JMP;
                        end
                        OP_JR: begin
                            next_pc      <= jr_next;
                            misalign_reg <= jr_misalign;
                            done         <= 1'b1;
                            pc_write     <= 1'b1;
                            state_reg    <= ST_DONE;
                        end
                        default: state_reg <= ST_IDLE;
                    endcase
                end

                ST_SHIFT: begin
                    off_reg   <= off_next;
                    state_reg <= ST_ADD;
                end

                ST_ADD: begin
                    // The sum wraps mod 2^32. A carry out of bit 31 is dropped.
                    next_pc   <= add_next;
                    done      <= 1'b1;
                    pc_write  <= 1'b1;
                    state_reg <= ST_DONE;
                end

                ST_JMP: begin
                    next_pc   <= jmp_next;
                    done      <= 1'b1;
                    pc_write  <= 1'b1;
                    state_reg <= ST_DONE;
                end

                ST_DONE: begin
                    // A start seen here is dropped. Requests are taken only from IDLE.
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign misalign = misalign_reg;
`else
    // misalign_reg is cleared every cycle when the alignment check is absent.
    logic unused_misalign;
    assign unused_misalign = misalign_reg;
`endif

endmodule

// File: tb/tb_branch_target_sequencer.sv
module tb_branch_target_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [31:0] rs_val;
    logic        take;
    logic        busy;
    logic        done;
    logic        pc_write;
    logic [31:0] next_pc;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    branch_target_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .pc       (pc),
        .imm      (imm),
        .jaddr    (jaddr),
        .rs_val   (rs_val),
        .take     (take),
        .busy     (busy),
        .done     (done),
        .pc_write (pc_write),
`ifdef PC_SEQ_ALIGN_CHECK_EN
        .misalign (misalign),
`endif
        .next_pc  (next_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model written from the architectural rules, not the FSM
    function automatic void model(input logic [1:0] m_op, input logic [31:0] m_pc,
                                  input logic [15:0] m_imm, input logic [25:0] m_ja,
                                  input logic [31:0] m_rs, input logic m_take,
                                  output logic [31:0] m_npc, output int m_lat,
                                  output logic m_mis);
        logic [31:0] pc4;
        logic [31:0] off;
        pc4   = m_pc + 32'd4;
        off   = {{16{m_imm[15]}}, m_imm} * 32'd4;
        m_mis = 1'b0;
        case (m_op)
            2'd0: begin m_npc = pc4; m_lat = 2; end
            2'd1: begin
                if (m_take) begin m_npc = pc4 + off; m_lat = 4; end
                else        begin m_npc = pc4;       m_lat = 2; end
            end
            2'd2: begin m_npc = (pc4 & 32'hF000_0000) | ({6'd0, m_ja} * 32'd4); m_lat = 3; end
            default: begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
                m_npc = m_rs & 32'hFFFF_FFFC;
                m_mis = (m_rs % 4) != 0;
`else
                m_npc = m_rs;
`endif
                m_lat = 2;
            end
        endcase
    endfunction

    // One request: accept, track latency, check the done cycle and the cycle after.
    task automatic run_txn(input logic [1:0] t_op, input logic [31:0] t_pc,
                           input logic [15:0] t_imm, input logic [25:0] t_ja,
                           input logic [31:0] t_rs, input logic t_take,
                           input logic hold);
        logic [31:0] exp_npc;
        int          exp_lat;
        logic        exp_mis;
        int          k;
        bit          got_done;
        model(t_op, t_pc, t_imm, t_ja, t_rs, t_take, exp_npc, exp_lat, exp_mis);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        op = t_op; pc = t_pc; imm = t_imm; jaddr = t_ja; rs_val = t_rs; take = t_take;
        start = 1'b1;
        @(posedge clk);
        k = 0;
        got_done = 0;
        while (!got_done && k < 10) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                // Operands after accept must not matter
                start = hold;
                op = 2'($urandom); pc = $urandom; imm = 16'($urandom);
                jaddr = 26'($urandom); rs_val = $urandom; take = 1'($urandom);
            end
            if (done) got_done = 1;
            else check("busy_during", {31'd0, busy}, 32'd1);
        end
        if (!got_done) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", k, exp_lat);
            check("next_pc", next_pc, exp_npc);
            check("pc_write", {31'd0, pc_write}, 32'd1);
            check("busy_done", {31'd0, busy}, 32'd1);
`ifdef PC_SEQ_ALIGN_CHECK_EN
            check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
`endif
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", {31'd0, done}, 32'd0);
            check("pcw_pulse", {31'd0, pc_write}, 32'd0);
            check("busy_after", {31'd0, busy}, 32'd0);
            check("npc_hold", next_pc, exp_npc);
`ifdef PC_SEQ_ALIGN_CHECK_EN
            check("misalign_clr", {31'd0, misalign}, 32'd0);
`endif
        end
        $display("txn op=%0d pc=%h imm=%h ja=%h rs=%h take=%0d hold=%0d -> npc=%h lat=%0d",
                 t_op, t_pc, t_imm, t_ja, t_rs, t_take, hold, exp_npc, exp_lat);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; pc = 32'h0; imm = 16'h0;
        jaddr = 26'h0; rs_val = 32'h0; take = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pcw", {31'd0, pc_write}, 32'd0);
        check("rst_npc", next_pc, 32'h0000_0000);
        reset = 1'b0;

        // Directed cases
        run_txn(2'd0, 32'h0040_0000, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        run_txn(2'd1, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0, 1'b1, 1'b0);
        run_txn(2'd1, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0);
        run_txn(2'd2, 32'h9000_0000, 16'h0, 26'h010_0000, 32'h0, 1'b0, 1'b0);
        run_txn(2'd3, 32'h0, 16'h0, 26'h0, 32'h0040_0102, 1'b0, 1'b1);
        run_txn(2'd0, 32'hFFFF_FFFC, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        run_txn(2'd1, 32'hFFFF_FFF0, 16'h7FFF, 26'h0, 32'h0, 1'b1, 1'b1);

        // Reset while in SHIFT aborts the request
        @(negedge clk);
        op = 2'd1; pc = 32'h0000_1000; imm = 16'h0010; take = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_npc", next_pc, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        $display("txn reset mid-SHIFT abort");
        run_txn(2'd0, 32'h0000_2000, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);

        // Randomized requests
        for (int n = 0; n < 200; n++) begin
            logic [31:0] rpc;
            rpc = $urandom & 32'hFFFF_FFFC;
            if (n % 17 == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hC);
            run_txn(2'($urandom), rpc, 16'($urandom), 26'($urandom), $urandom,
                    1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
